ex_stage_muldiv: RTL and testbench

//  Execute stage feeding MEMandWB: ALU + iterative MULTU/DIVU unit + HI/LO regs.

---
 rtl/ex_stage_muldiv.sv | 175 +++++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_muldiv.sv
// Execute stage: ALU, iterative MULTU/DIVU and HI/LO, registered towards MEM/WB.
// Latency: single-cycle ops 1 cycle; MULTU/DIVU hold Stall high for ITER cycles.
// Backpressure: Stall=1 turns every cycle into a bubble; upstream holds its instruction.
module ex_stage_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             OpValid,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [WIDTH-1:0] SignImm,
    input  logic [4:0]       Shamt,
    input  logic             ALUSrc,
    input  logic [3:0]       ALUControl,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic             MemtoRegIn,
    input  logic             RegWriteIn,
    output logic [WIDTH-1:0] AlUResult,
    output logic [WIDTH-1:0] ReadData2Out,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Zero,
    output logic             Stall
);
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
    localparam int         CW       = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] acc_hi, acc_lo, md_b;
    logic [WIDTH-1:0] opb, alu_res;
    logic             is_md, accept, load, start, done;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, rem_nxt, quo_nxt;
    logic             div_ok, slt;

    assign opb    = ALUSrc ? SignImm : ReadData2;
    assign slt    = $signed(ReadData1) < $signed(opb);
    assign is_md  = (ALUControl == OP_MULTU) || (ALUControl == OP_DIVU);
    assign accept = OpValid && !Stall;
    assign load   = accept && !is_md;
    assign start  = accept && is_md && (state == S_IDLE);
    assign done   = (cnt == CW'(ITER - 1));

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OP_AND:  alu_res = ReadData1 & opb;
            OP_OR:   alu_res = ReadData1 | opb;
            OP_ADD:  alu_res = ReadData1 + opb;
            OP_SUB:  alu_res = ReadData1 - opb;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR:  alu_res = ~(ReadData1 | opb);
            OP_SLL:  alu_res = opb << Shamt;
            OP_SRL:  alu_res = opb >> Shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiply: acc_hi collects partial sums, acc_lo shifts the multiplier out.
    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : '0);
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring divide: a zero divisor never borrows, giving all-ones quotient and remainder = A.
    assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, md_b};
    assign div_ok     = !div_trial[WIDTH];
    assign rem_nxt    = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_nxt    = {acc_lo[WIDTH-2:0], div_ok};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (ALUControl == OP_MULTU) ? S_MUL : S_DIV;
            S_MUL,
            S_DIV:   if (done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            md_b   <= '0;
            Stall  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    acc_hi <= '0;
                    acc_lo <= ReadData1;
                    md_b   <= ReadData2;
                    cnt    <= '0;
                    Stall  <= 1'b1;
                end
                S_MUL: begin
                    acc_hi <= mul_hi_nxt;
                    acc_lo <= mul_lo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (done) begin
                        hi    <= mul_hi_nxt;
                        lo    <= mul_lo_nxt;
                        Stall <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc_hi <= rem_nxt;
                    acc_lo <= quo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (done) begin
                        hi    <= rem_nxt;
                        lo    <= quo_nxt;
                        Stall <= 1'b0;
                    end
                end
                default: Stall <= 1'b0;
            endcase
        end
    end

    // Bubbles clear only the side-effecting controls; result, Zero and store data hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            AlUResult    <= '0;
            ReadData2Out <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            MemtoReg     <= 1'b0;
            RegWrite     <= 1'b0;
            Zero         <= 1'b0;
        end else if (load) begin
            AlUResult    <= alu_res;
            ReadData2Out <= ReadData2;
            MemRead      <= MemReadIn;
            MemWrite     <= MemWriteIn;
            MemtoReg     <= MemtoRegIn;
            RegWrite     <= RegWriteIn;
            Zero         <= (alu_res == '0);
        end else begin
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            RegWrite     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboarded bench for ex_stage_muldiv: directed cases plus random ops against an arithmetic model.
module tb_ex_stage_muldiv;
    logic        Clk, Rst_n, OpValid, ALUSrc;
    logic [31:0] ReadData1, ReadData2, SignImm;
    logic [4:0]  Shamt;
    logic [3:0]  ALUControl;
    logic        MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn;
    logic [31:0] AlUResult, ReadData2Out;
    logic        MemRead, MemWrite, MemtoReg, RegWrite, Zero, Stall;

    ex_stage_muldiv #(.WIDTH(32), .ITER(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .OpValid(OpValid),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SignImm(SignImm),
        .Shamt(Shamt), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
        .AlUResult(AlUResult), .ReadData2Out(ReadData2Out),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .Zero(Zero), .Stall(Stall)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rd2o;
        logic        mr, mw, m2r, rw, zero, stall;
    } obs_t;

    obs_t        exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi, m_lo;
    int          m_busy;
    obs_t        m_out;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b1000: return b << sh;
            4'b1001: return b >> sh;
            4'b1101: return m_hi;
            4'b1110: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Reference behaviour for one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        logic [31:0] b, r;
        logic [63:0] p;
        b = ALUSrc ? SignImm : ReadData2;
        if (m_busy > 0) begin
            m_busy--;
            m_out.mr = 0; m_out.mw = 0; m_out.rw = 0;
        end else if (OpValid && (ALUControl == 4'b1010 || ALUControl == 4'b1011)) begin
            if (ALUControl == 4'b1010) begin
                p = {32'd0, ReadData1} * {32'd0, ReadData2};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end else if (ReadData2 == 0) begin
                m_lo = 32'hFFFFFFFF;
                m_hi = ReadData1;
            end else begin
                m_lo = ReadData1 / ReadData2;
                m_hi = ReadData1 % ReadData2;
            end
            m_busy = 32;
            m_out.mr = 0; m_out.mw = 0; m_out.rw = 0;
        end else if (OpValid) begin
            r = ref_alu(ALUControl, ReadData1, b, Shamt);
            m_out.res  = r;
            m_out.rd2o = ReadData2;
            {m_out.mr, m_out.mw, m_out.m2r, m_out.rw} = {MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn};
            m_out.zero = (r == 0);
        end else begin
            m_out.mr = 0; m_out.mw = 0; m_out.rw = 0;
        end
        m_out.stall = (m_busy > 0);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh,
                         input logic src, input logic [3:0] ctl, input string nm);
        OpValid = v; ALUControl = op; ReadData1 = a; ReadData2 = b;
        SignImm = imm; Shamt = sh; ALUSrc = src;
        {MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn} = ctl;
        @(posedge Clk);
        model_edge();
        exp_q.push_back(m_out);
        name_q.push_back(nm);
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 0, 0, 0, 0, 1'b0, 4'h0, nm);
    endtask

    task automatic apply_reset(input string nm);
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        m_hi = 0; m_lo = 0; m_busy = 0; m_out = '0;
        exp_q.push_back(m_out);
        name_q.push_back(nm);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        obs_t  e, a;
        string nm;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {AlUResult, ReadData2Out, MemRead, MemWrite, MemtoReg, RegWrite, Zero, Stall};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL %s: got res=%h rd2=%h mr/mw/m2r/rw=%b%b%b%b zero=%b stall=%b, want res=%h rd2=%h mr/mw/m2r/rw=%b%b%b%b zero=%b stall=%b",
                              nm, a.res, a.rd2o, a.mr, a.mw, a.m2r, a.rw, a.zero, a.stall,
                              e.res, e.rd2o, e.mr, e.mw, e.m2r, e.rw, e.zero, e.stall);
            end
        end
    end

    initial begin
        logic [3:0] op;
        Rst_n = 1'b0; OpValid = 0; ALUControl = 0; ReadData1 = 0; ReadData2 = 0;
        SignImm = 0; Shamt = 0; ALUSrc = 0;
        {MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn} = 4'h0;
        m_hi = 0; m_lo = 0; m_busy = 0; m_out = '0;

        apply_reset("reset");
        drive(1, 4'b0010, 32'd5, 32'hFFFFFFF9, 0, 0, 0, 4'b0001, "add_5_m7");
        drive(1, 4'b0110, 32'd9, 32'd9, 0, 0, 0, 4'b0100, "sub_9_9_store");
        idle(1, "bubble_hold");
        drive(1, 4'b0010, 32'd100, 32'd3, 32'hFFFFFFFC, 0, 1, 4'b1011, "add_imm_load");
        drive(1, 4'b0111, 32'hFFFFFFF1, 32'd8, 0, 0, 0, 4'b0001, "slt_m15_8");
        drive(1, 4'b0111, 32'd8, 32'hFFFFFFF1, 0, 0, 0, 4'b0001, "slt_8_m15");
        drive(1, 4'b1001, 0, 32'h80000000, 0, 5'd31, 0, 4'b0001, "srl_31");
        drive(1, 4'b1000, 0, 32'h00000003, 0, 5'd4, 0, 4'b0001, "sll_4");
        drive(1, 4'b1100, 32'h0F0F0000, 32'h000000F0, 0, 0, 0, 4'b0001, "nor");
        drive(1, 4'b1111, 32'h1234, 32'h5678, 0, 0, 0, 4'b0001, "undefined_op");

        drive(1, 4'b1010, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 4'b0001, "multu_accept");
        for (int i = 0; i < 32; i++)
            drive(1, 4'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  4'($urandom), "multu_stall");
        drive(1, 4'b1101, 0, 0, 0, 0, 0, 4'b0001, "mfhi_after_multu");
        drive(1, 4'b1110, 0, 0, 0, 0, 0, 4'b0001, "mflo_after_multu");

        drive(1, 4'b1011, 32'd100, 32'd7, 32'd1, 0, 1, 4'b0001, "divu_100_7");
        idle(32, "divu_stall");
        drive(1, 4'b1110, 0, 0, 0, 0, 0, 4'b0001, "mflo_div");
        drive(1, 4'b1101, 0, 0, 0, 0, 0, 4'b0001, "mfhi_div");
        drive(1, 4'b1011, 32'd5, 32'd0, 0, 0, 0, 4'b0001, "divu_5_0");
        idle(32, "divu0_stall");
        drive(1, 4'b1110, 0, 0, 0, 0, 0, 4'b0001, "mflo_div0");
        drive(1, 4'b1101, 0, 0, 0, 0, 0, 4'b0001, "mfhi_div0");

        drive(1, 4'b1010, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 4'b0001, "multu_abort");
        idle(10, "multu_abort_stall");
        apply_reset("reset_mid_op");
        drive(1, 4'b1101, 0, 0, 0, 0, 0, 4'b0001, "mfhi_after_abort");
        drive(1, 4'b0010, 32'd40, 32'd2, 0, 0, 0, 4'b0001, "add_after_abort");

        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom);
            drive(1'($urandom_range(0, 3) != 0), op, $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  $urandom, 5'($urandom), 1'($urandom), 4'($urandom), "random");
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
